// File: rtl/dma_ch_scheduler_if.sv
// Channel-engine side of the DMA port scheduler: requests, quanta, aborts, beat strobe and grant outputs.
interface dma_ch_scheduler_if #(
  parameter int NUM_CH        = 2,
  parameter int QUANTUM_WIDTH = 4,
  parameter int ID_WIDTH      = $clog2(NUM_CH)
);
  logic                                  aenable;
  logic [NUM_CH-1:0]                     i_req;
  logic [NUM_CH-1:0][QUANTUM_WIDTH-1:0]  i_quantum;
  logic [NUM_CH-1:0]                     i_abort;
  logic                                  i_beat_done;
  logic [NUM_CH-1:0]                     o_grant;
  logic                                  o_grant_valid;
  logic [ID_WIDTH-1:0]                   o_grant_id;
  logic [QUANTUM_WIDTH-1:0]              o_beats_left;
  logic                                  o_abort_done;

  modport master (
    output aenable, i_req, i_quantum, i_abort, i_beat_done,
    input  o_grant, o_grant_valid, o_grant_id, o_beats_left, o_abort_done
  );

  modport slave (
    input  aenable, i_req, i_quantum, i_abort, i_beat_done,
    output o_grant, o_grant_valid, o_grant_id, o_beats_left, o_abort_done
  );
endinterface

// File: rtl/dma_ch_scheduler.sv
// Time-slice owner of the shared AXI-lite port: registered one-hot grant, 1-cycle request/handover latency.
// DMA_SCHED_RR_EN selects round-robin arbitration; otherwise the highest eligible index wins.
module dma_ch_scheduler #(
  parameter int NUM_CH        = 2,
  parameter int QUANTUM_WIDTH = 4,
  parameter int ID_WIDTH      = $clog2(NUM_CH)
) (
  input  logic              aclk,
  input  logic              areset,
  dma_ch_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, ABORTING} state_e;

  state_e                   state_q, state_d;
  logic [NUM_CH-1:0]        grant_q, grant_d;
  logic [ID_WIDTH-1:0]      owner_q, owner_d;
  logic [QUANTUM_WIDTH-1:0] cnt_q, cnt_d;
  logic                     abort_done_q, abort_done_d;

  logic [NUM_CH-1:0]        elig;
  logic                     any_abort;
  logic                     any_elig;
  logic                     release_c;
  logic [ID_WIDTH-1:0]      win_id;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      elig[i] = bus.i_req[i] && (bus.i_quantum[i] != '0) && !bus.i_abort[i];
    end
  end

  assign any_abort = |bus.i_abort;
  assign any_elig  = |elig;

`ifdef DMA_SCHED_RR_EN
  logic [ID_WIDTH-1:0] ptr_q, ptr_d, start_id;
  int                  best_dist;
  int                  dist;

  function automatic logic [ID_WIDTH-1:0] next_id(input logic [ID_WIDTH-1:0] id);
    return (int'(id) == NUM_CH - 1) ? '0 : id + 1'b1;
  endfunction

  // On a release the search must already start past the outgoing owner, so the
  // owner is only chosen again when nobody else is eligible.
  always_comb begin
    win_id    = '0;
    best_dist = NUM_CH;
    dist      = 0;
    start_id  = (state_q == GRANT) ? next_id(owner_q) : ptr_q;
    for (int i = 0; i < NUM_CH; i++) begin
      dist = (i + NUM_CH - int'(start_id)) % NUM_CH;
      if (elig[i] && (dist < best_dist)) begin
        best_dist = dist;
        win_id    = ID_WIDTH'(i);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (release_c) ptr_d = next_id(owner_q);
  end

  always_ff @(posedge aclk) begin
    if (areset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  always_comb begin
    win_id = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (elig[i]) win_id = ID_WIDTH'(i);
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    abort_done_d = 1'b0;
    release_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_abort) begin
          state_d = ABORTING;
        end else if (bus.aenable && any_elig) begin
          state_d = GRANT;
          grant_d = NUM_CH'(1) << win_id;
          owner_d = win_id;
          cnt_d   = bus.i_quantum[win_id];
        end
      end
      GRANT: begin
        if (any_abort) begin
          state_d = ABORTING;
          grant_d = '0;
          cnt_d   = '0;
        end else begin
          release_c = (bus.i_beat_done && (cnt_q == QUANTUM_WIDTH'(1))) || !bus.i_req[owner_q];
          if (release_c) begin
            if (bus.aenable && any_elig) begin
              grant_d = NUM_CH'(1) << win_id;
              owner_d = win_id;
              cnt_d   = bus.i_quantum[win_id];
            end else begin
              state_d = IDLE;
              grant_d = '0;
              cnt_d   = '0;
            end
          end else if (bus.i_beat_done) begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      ABORTING: begin
        if (!any_abort) begin
          state_d      = IDLE;
          abort_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      cnt_q        <= '0;
      abort_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      abort_done_q <= abort_done_d;
    end
  end

  assign bus.o_grant       = grant_q;
  assign bus.o_grant_valid = |grant_q;
  assign bus.o_grant_id    = owner_q;
  assign bus.o_beats_left  = cnt_q;
  assign bus.o_abort_done  = abort_done_q;

endmodule
